// File: rtl/mdu_pkg.sv
// ----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit: operation encodings,
// sequencer state enum and operand width. D-stage decode imports this package
// too, so both sides agree on the op numbering.
// ----------------------------------------------------------------------------
package mdu_pkg;

    localparam int MDU_W = 32;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_calc.sv
// ----------------------------------------------------------------------------
// mdu_calc
// Purely combinational arithmetic for the MDU. The sequencer samples these
// results in the start cycle and holds them until the busy window expires.
// Ports:
//   op      in  3   MDU op encoding (mdu_pkg)
//   rs, rt  in  32  operands (dividend/divisor for divides)
//   res_hi  out 32  HI result (product upper word or remainder)
//   res_lo  out 32  LO result (product lower word or quotient)
//   div0    out 1   divide op with rt==0; the commit must be suppressed
// ----------------------------------------------------------------------------
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]       op,
    input  logic [MDU_W-1:0] rs,
    input  logic [MDU_W-1:0] rt,
    output logic [MDU_W-1:0] res_hi,
    output logic [MDU_W-1:0] res_lo,
    output logic             div0
);

    logic [2*MDU_W-1:0] prod_s;
    logic [2*MDU_W-1:0] prod_u;
    logic               is_signed_div;
    logic               neg_a;
    logic               neg_b;
    logic [MDU_W-1:0]   a_mag;
    logic [MDU_W-1:0]   b_mag;
    logic [MDU_W-1:0]   b_safe;
    logic [MDU_W-1:0]   q_mag;
    logic [MDU_W-1:0]   r_mag;
    logic [MDU_W-1:0]   q_signed;
    logic [MDU_W-1:0]   r_signed;

    // The low 2W bits of a product of sign-extended operands equal the
    // two's-complement signed product, so one unsigned multiplier shape
    // covers both mult and multu.
    assign prod_s = {{MDU_W{rs[MDU_W-1]}}, rs} * {{MDU_W{rt[MDU_W-1]}}, rt};
    assign prod_u = {{MDU_W{1'b0}}, rs} * {{MDU_W{1'b0}}, rt};

    // Signed divide is done on magnitudes and the signs re-applied: quotient
    // is negative when the operand signs differ, remainder takes the sign of
    // the dividend. 0x80000000 / -1 falls out as quotient 0x80000000, rem 0.
    // The divisor is forced non-zero so the divider never sees x/0; div0 tells
    // the sequencer to drop the result anyway.
    always_comb begin
        is_signed_div = (op == MDU_DIV);
        neg_a    = is_signed_div & rs[MDU_W-1];
        neg_b    = is_signed_div & rt[MDU_W-1];
        a_mag    = neg_a ? -rs : rs;
        b_mag    = neg_b ? -rt : rt;
        b_safe   = (b_mag == '0) ? {{(MDU_W-1){1'b0}}, 1'b1} : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        q_signed = (neg_a ^ neg_b) ? -q_mag : q_mag;
        r_signed = neg_a ? -r_mag : r_mag;
    end

    // Result select by op; non-arithmetic ops produce zeros, which the
    // sequencer never latches.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        div0   = 1'b0;
        case (op)
            MDU_MULT: begin
                res_hi = prod_s[2*MDU_W-1:MDU_W];
                res_lo = prod_s[MDU_W-1:0];
            end
            MDU_MULTU: begin
                res_hi = prod_u[2*MDU_W-1:MDU_W];
                res_lo = prod_u[MDU_W-1:0];
            end
            MDU_DIV, MDU_DIVU: begin
                res_hi = r_signed;
                res_lo = q_signed;
                div0   = (rt == '0);
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
                div0   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// ----------------------------------------------------------------------------
// mdu_ctrl
// E-stage multiply/divide sequencer. Accepts one op per start pulse, holds
// the unit busy for a fixed latency and commits HI/LO when the count runs
// out. mthi/mtlo write HI/LO in one cycle without entering RUN. An op whose
// start cycle coincides with IntExcReq is flushed and has no effect.
// Ports:
//   clk         in  1   clock, rising edge
//   reset       in  1   synchronous active-high reset
//   start       in  1   E-stage MDU op valid
//   op          in  3   op encoding (mdu_pkg)
//   rs, rt      in  32  forwarded operands
//   IntExcReq   in  1   exception taken; flushes the E-stage op
//   d_md_class  in  1   D-stage instruction is MDU class
//   busy        out 1   multi-cycle op in progress (registered)
//   md_stall    out 1   stall request for D-stage MDU-class instructions
//   hi, lo      out 32  architectural HI/LO
// ----------------------------------------------------------------------------
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [MDU_W-1:0] rs,
    input  logic [MDU_W-1:0] rt,
    input  logic             IntExcReq,
    input  logic             d_md_class,
    output logic             busy,
    output logic             md_stall,
    output logic [MDU_W-1:0] hi,
    output logic [MDU_W-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MDU_W-1:0] pend_hi_q, pend_hi_d;
    logic [MDU_W-1:0] pend_lo_q, pend_lo_d;
    logic             pend_div0_q, pend_div0_d;
    logic [MDU_W-1:0] hi_q, hi_d;
    logic [MDU_W-1:0] lo_q, lo_d;

    logic [MDU_W-1:0] res_hi;
    logic [MDU_W-1:0] res_lo;
    logic             div0;
    logic             accept;
    logic             is_arith;
    logic             is_div;

    mdu_calc u_calc (
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    assign accept   = start & ~IntExcReq;
    assign is_arith = (op <= MDU_DIVU);
    assign is_div   = (op == MDU_DIV) | (op == MDU_DIVU);

    // The stall also covers the start cycle itself, because busy only rises
    // on the following edge.
    assign busy     = (state_q == MDU_RUN);
    assign md_stall = d_md_class & (busy | (start & is_arith & ~IntExcReq));
    assign hi       = hi_q;
    assign lo       = lo_q;

    // Next-state logic. In RUN, start and IntExcReq are ignored: the running
    // op belongs to an instruction that has already left E.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_div0_d = pend_div0_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            MDU_IDLE: begin
                if (accept) begin
                    if (is_arith) begin
                        state_d     = MDU_RUN;
                        cnt_d       = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        pend_hi_d   = res_hi;
                        pend_lo_d   = res_lo;
                        pend_div0_d = div0;
                    end else if (op == MDU_MTHI) begin
                        hi_d = rs;
                    end else if (op == MDU_MTLO) begin
                        lo_d = rs;
                    end
                end
            end
            MDU_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MDU_IDLE;
                    cnt_d   = '0;
                    if (!pend_div0_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; reset discards any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MDU_IDLE;
            cnt_q       <= '0;
            pend_hi_q   <= '0;
            pend_lo_q   <= '0;
            pend_div0_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_div0_q <= pend_div0_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    // A start while RUN means the hazard unit failed to honour md_stall.
    always @(posedge clk) begin
        if (!reset && state_q == MDU_RUN) begin
            assert (!start);
        end
    end

endmodule
